// File: rtl/clock_enable_pkg.sv
// Shared defaults and config record for the clock-enable counter.
// Optional feature macro: CLOCK_ENABLE_COUNTER_SAT_EN (saturating counters, sticky wrap).
package clock_enable_pkg;

  localparam int unsigned CH_DEF      = 2;
  localparam int unsigned DIV_W_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 4;
  localparam int unsigned RST_DIV_DEF = 1;

  // Per-channel configuration record at the default field width.
  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] phase;
  } ch_cfg_t;

endpackage

// File: rtl/ce_channel.sv
// One channel: prescaler producing a one-cycle enable strobe, plus strobe counter and wrap flag.
// Optional feature macro: CLOCK_ENABLE_COUNTER_SAT_EN (saturating counter, sticky wrap).
module ce_channel
  import clock_enable_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RST_DIV = RST_DIV_DEF
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             load,
  input  logic             cnt_en,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             ce,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0] d_r;
  logic [DIV_W-1:0] p;
  logic [DIV_W-1:0] d_n;
  logic [DIV_W-1:0] p_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ce_n;
  logic             wrap_n;
  logic             hit;

  // Next-state: load realigns, enabled cycles advance the prescaler, otherwise hold.
  always_comb begin
    d_n    = d_r;
    p_n    = p;
    cnt_n  = cnt;
    ce_n   = 1'b0;
`ifdef CLOCK_ENABLE_COUNTER_SAT_EN
    wrap_n = wrap;
`else
    wrap_n = 1'b0;
`endif
    hit    = (p == d_r);
    if (load) begin
      d_n    = div;
      p_n    = (phase > div) ? div : phase;
      cnt_n  = '0;
      wrap_n = 1'b0;
    end else if (cnt_en) begin
      if (hit) begin
        p_n  = '0;
        ce_n = 1'b1;
`ifdef CLOCK_ENABLE_COUNTER_SAT_EN
        if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
        wrap_n = wrap | (cnt_n == CNT_MAX);
`else
        cnt_n  = cnt + CNT_W'(1);
        wrap_n = (cnt == CNT_MAX);
`endif
      end else begin
        p_n = p + DIV_W'(1);
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      d_r  <= DIV_W'(RST_DIV);
      p    <= '0;
      cnt  <= '0;
      ce   <= 1'b0;
      wrap <= 1'b0;
    end else begin
      d_r  <= d_n;
      p    <= p_n;
      cnt  <= cnt_n;
      ce   <= ce_n;
      wrap <= wrap_n;
    end
  end

endmodule

// File: rtl/clock_enable_counter.sv
// Multi-channel clock-enable generator: slices the buses and broadcasts load/cnt_en.
// Optional feature macro: CLOCK_ENABLE_COUNTER_SAT_EN (saturating counters, sticky wrap).
module clock_enable_counter
  import clock_enable_pkg::*;
#(
  parameter int unsigned CH      = CH_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RST_DIV = RST_DIV_DEF
) (
  input  logic                clk_100M,
  input  logic                rst,
  input  logic                load,
  input  logic [CH*DIV_W-1:0] div,
  input  logic [CH*DIV_W-1:0] phase,
  input  logic                cnt_en,
  output logic [CH-1:0]       ce,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       wrap
);

  // One independent channel per slice.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    ce_channel #(
      .DIV_W   (DIV_W),
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk_100M (clk_100M),
      .rst      (rst),
      .load     (load),
      .cnt_en   (cnt_en),
      .div      (div[i*DIV_W +: DIV_W]),
      .phase    (phase[i*DIV_W +: DIV_W]),
      .ce       (ce[i]),
      .cnt      (cnt[i*CNT_W +: CNT_W]),
      .wrap     (wrap[i])
    );
  end

endmodule
